// File: rtl/hpdcache_req_arbiter.sv
// hpdcache_req_arbiter: round-robin N-requester front-end for a single-requester HPDcache port,
// with per-requester outstanding-response limits and SID-based response routing.
// Optional priority class is compiled in when HPDCACHE_ARB_PRIO_EN is defined.
module hpdcache_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned REQ_W   = 128,
  parameter int unsigned RSP_W   = 64,
  parameter int unsigned SID_W   = 3,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*REQ_W-1:0] req_data_i,
  input  logic [NREQ-1:0]       req_need_rsp_i,
`ifdef HPDCACHE_ARB_PRIO_EN
  input  logic [NREQ-1:0]       req_prio_i,
`endif
  output logic                  c_req_valid_o,
  input  logic                  c_req_ready_i,
  output logic [REQ_W-1:0]      c_req_data_o,
  output logic [SID_W-1:0]      c_req_sid_o,
  input  logic                  c_rsp_valid_i,
  input  logic [SID_W-1:0]      c_rsp_sid_i,
  input  logic [RSP_W-1:0]      c_rsp_data_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  output logic [RSP_W-1:0]      rsp_data_o,
  output logic                  err_sid_o
);

  localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);
  localparam int unsigned SIDX_W = SID_W + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [PTR_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];
  logic             err_q, err_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0] rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]  eligible;
  logic [PTR_W-1:0] arb_idx;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             gnt_prio;
  logic             accept;
  logic             rsp_sid_ok;

`ifdef HPDCACHE_ARB_PRIO_EN
  logic             lock_prio_q, lock_prio_d;
  logic [NREQ-1:0]  prio_elig;
`endif

  // First set bit of mask at or after start, wrapping modulo NREQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] mask,
                                               input logic [PTR_W-1:0] start);
    logic [PTR_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = start;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(start) + i) % NREQ;
      if (!found && mask[idx]) begin
        pick  = PTR_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Eligibility, arbitration and grant lock.
  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      eligible[k] = req_valid_i[k] && (!req_need_rsp_i[k] || (cnt_q[k] < CNT_W'(MAX_OUT)));
    end
`ifdef HPDCACHE_ARB_PRIO_EN
    prio_elig = eligible & req_prio_i;
    arb_idx   = (|prio_elig) ? rr_pick(prio_elig, ptr_q) : rr_pick(eligible, ptr_q);
    gnt_prio  = lock_q ? lock_prio_q : (|prio_elig);
`else
    arb_idx   = rr_pick(eligible, ptr_q);
    gnt_prio  = 1'b0;
`endif
    gnt_idx   = lock_q ? lock_idx_q : arb_idx;
    gnt_valid = lock_q || (|eligible);
    accept    = gnt_valid && c_req_ready_i;
    req_ready_o = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      req_ready_o[k] = accept && (gnt_idx == PTR_W'(k));
    end
  end

  assign c_req_valid_o = gnt_valid;
  assign c_req_data_o  = req_data_i[32'(gnt_idx)*REQ_W +: REQ_W];
  assign c_req_sid_o   = SID_W'(gnt_idx);
  assign rsp_sid_ok    = {1'b0, c_rsp_sid_i} < SIDX_W'(NREQ);

  // Next state: pointer, lock, outstanding counters, response stage, error flag.
  always_comb begin
    logic inc;
    logic dec;
    inc         = 1'b0;
    dec         = 1'b0;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    err_d       = err_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef HPDCACHE_ARB_PRIO_EN
    lock_prio_d = lock_prio_q;
`endif

    if (accept) begin
      lock_d = 1'b0;
      // Priority grants leave the pointer alone so the low class stays fair.
      if (!gnt_prio) begin
        ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
    end else if (gnt_valid && !lock_q) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
`ifdef HPDCACHE_ARB_PRIO_EN
      lock_prio_d = gnt_prio;
`endif
    end

    if (c_rsp_valid_i) begin
      if (rsp_sid_ok) begin
        rsp_data_d = c_rsp_data_i;
      end else begin
        err_d = 1'b1;
      end
    end

    for (int unsigned k = 0; k < NREQ; k++) begin
      inc      = accept && req_need_rsp_i[k] && (gnt_idx == PTR_W'(k));
      dec      = c_rsp_valid_i && (c_rsp_sid_i == SID_W'(k));
      cnt_d[k] = cnt_q[k];
      rsp_valid_d[k] = dec;
      if (inc && !dec) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[k] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
        cnt_q[k] <= '0;
      end
`ifdef HPDCACHE_ARB_PRIO_EN
      lock_prio_q <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int unsigned k = 0; k < NREQ; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
`ifdef HPDCACHE_ARB_PRIO_EN
      lock_prio_q <= lock_prio_d;
`endif
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign err_sid_o   = err_q;

endmodule
